// File: rtl/axi_lite_master_if.sv
// AXI4-Lite channel bundle between one master and one slave.
interface axi_lite_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wlast;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, wlast, input wready,
        input bvalid, bresp, output bready,
        output araddr, arvalid, input arready,
        input rdata, rvalid, rlast, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wvalid, wlast, output wready,
        output bvalid, bresp, input bready,
        input araddr, arvalid, output arready,
        output rdata, rvalid, rlast, input rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one local command becomes one AXI read or write.
// Optional wait-state watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | accepting a local command
// WR_ADDR | awvalid up, waiting for awready
// WR_DATA | wvalid/wlast up, waiting for wready
// WR_RESP | bready up, waiting for bvalid
// RD_ADDR | arvalid up, waiting for arready
// RD_DATA | rready up, waiting for rvalid
// DONE    | one-cycle rsp_valid pulse
module axi_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    axi_lite_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wait_expired;
    logic              tmo_fire;
    wire               unused_rlast = bus.rlast;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // A handshake always wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        tmo_fire    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !areset;
                if (cmd_valid && !areset) state_next = cmd_write ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                bus.awvalid = 1'b1;
                if (bus.awready) state_next = WR_DATA;
                else if (wait_expired) begin state_next = DONE; tmo_fire = 1'b1; end
            end
            WR_DATA: begin
                bus.wvalid = 1'b1;
                bus.wlast  = 1'b1;
                if (bus.wready) state_next = WR_RESP;
                else if (wait_expired) begin state_next = DONE; tmo_fire = 1'b1; end
            end
            WR_RESP: begin
                bus.bready = 1'b1;
                if (bus.bvalid) state_next = DONE;
                else if (wait_expired) begin state_next = DONE; tmo_fire = 1'b1; end
            end
            RD_ADDR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) state_next = RD_DATA;
                else if (wait_expired) begin state_next = DONE; tmo_fire = 1'b1; end
            end
            RD_DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid) state_next = DONE;
                else if (wait_expired) begin state_next = DONE; tmo_fire = 1'b1; end
            end
            DONE: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.awaddr = addr_q;
    assign bus.araddr = addr_q;
    assign bus.wdata  = wdata_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == WR_RESP && bus.bvalid) begin
            rsp_err <= (bus.bresp != 2'b00);
        end else if (state == RD_DATA && bus.rvalid) begin
            rsp_rdata <= bus.rdata;
            rsp_err   <= 1'b0;
        end else if (tmo_fire) begin
            rsp_err <= 1'b1;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] timer;

    // Reloaded on every state change, so each wait state gets its own budget.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                   timer <= '0;
        else if (state_next != state) timer <= TMO_LOAD;
        else if (timer != 8'd0)       timer <= timer - 8'd1;
    end

    assign wait_expired = (timer == 8'd0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                                rsp_timeout <= 1'b0;
        else if (state != DONE && state_next == DONE) rsp_timeout <= tmo_fire;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wait_expired = 1'b0;
    assign rsp_timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed table, hand sequences, randomized model check.
module tb_axi_lite_master;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BOUND = 64;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;

    axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .bus(bus)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (!areset) begin
            if (bus.awvalid && bus.awready) aw_hs <= aw_hs + 1;
            if (bus.wvalid  && bus.wready)  w_hs  <= w_hs + 1;
            if (bus.bvalid  && bus.bready)  b_hs  <= b_hs + 1;
            if (bus.arvalid && bus.arready) ar_hs <= ar_hs + 1;
            if (bus.rvalid  && bus.rready)  r_hs  <= r_hs + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // At most one AXI channel may be active at any time.
    always @(negedge aclk) begin
        if (areset === 1'b0)
            check("chan_excl",
                  64'($countones({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}) <= 1), 64'd1);
    end

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            aw_d, w_d, b_d;
        logic [1:0]    bresp;
        int            ar_d, r_d;
        logic [DW-1:0] rdata;
        bit            stray;
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    function automatic vec_t mkw(input logic [AW-1:0] a, input logic [DW-1:0] d, input int awd, input int wd,
                                 input int bd, input logic [1:0] br, input bit e, input logic [DW-1:0] er, input int lat);
        vec_t v;
        v = '{write: 1'b1, addr: a, wdata: d, aw_d: awd, w_d: wd, b_d: bd, bresp: br, ar_d: 0, r_d: 0,
              rdata: '0, stray: 1'b0, exp_err: e, exp_rdata: er, exp_lat: lat};
        return v;
    endfunction

    function automatic vec_t mkr(input logic [AW-1:0] a, input int ard, input int rd, input logic [DW-1:0] d,
                                 input bit s, input logic [DW-1:0] er, input int lat);
        vec_t v;
        v = '{write: 1'b0, addr: a, wdata: '0, aw_d: 0, w_d: 0, b_d: 0, bresp: 2'b00, ar_d: ard, r_d: rd,
              rdata: d, stray: s, exp_err: 1'b0, exp_rdata: er, exp_lat: lat};
        return v;
    endfunction

    function automatic logic out_of(input int ch);
        case (ch)
            0: return bus.awvalid;
            1: return bus.wvalid;
            2: return bus.bready;
            3: return bus.arvalid;
            4: return bus.rready;
            default: return rsp_valid;
        endcase
    endfunction

    task automatic wait_ch(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (out_of(ch) === 1'b1) begin ok = 1'b1; return; end
            @(negedge aclk);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int t0;
        bit ok;
        int aw0, w0, b0, ar0, r0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        t0 = cyc;
        @(negedge aclk);
        cmd_valid = 1'b0; cmd_addr = '1; cmd_wdata = '1;
        if (v.write) begin
            wait_ch(0, ok); check({tag, "_aw_seen"}, 64'(ok), 64'd1);
            repeat (v.aw_d) begin
                check({tag, "_awaddr_hold"}, 64'({bus.awvalid, bus.awaddr}), 64'({1'b1, v.addr}));
                @(negedge aclk);
            end
            check({tag, "_awaddr"}, 64'(bus.awaddr), 64'(v.addr));
            bus.awready = 1'b1; @(negedge aclk); bus.awready = 1'b0;
            check({tag, "_awvalid_drop"}, 64'(bus.awvalid), 64'd0);
            wait_ch(1, ok); check({tag, "_w_seen"}, 64'(ok), 64'd1);
            repeat (v.w_d) begin
                check({tag, "_wdata_hold"}, 64'({bus.wvalid, bus.wdata}), 64'({1'b1, v.wdata}));
                @(negedge aclk);
            end
            check({tag, "_wdata_wlast"}, 64'({bus.wlast, bus.wdata}), 64'({1'b1, v.wdata}));
            bus.wready = 1'b1; @(negedge aclk); bus.wready = 1'b0;
            check({tag, "_wvalid_drop"}, 64'(bus.wvalid), 64'd0);
            wait_ch(2, ok); check({tag, "_b_seen"}, 64'(ok), 64'd1);
            repeat (v.b_d) @(negedge aclk);
            bus.bvalid = 1'b1; bus.bresp = v.bresp; @(negedge aclk);
            bus.bvalid = 1'b0; bus.bresp = 2'b11;
            check({tag, "_bready_drop"}, 64'(bus.bready), 64'd0);
        end else begin
            wait_ch(3, ok); check({tag, "_ar_seen"}, 64'(ok), 64'd1);
            repeat (v.ar_d) begin
                check({tag, "_araddr_hold"}, 64'({bus.arvalid, bus.araddr}), 64'({1'b1, v.addr}));
                @(negedge aclk);
            end
            check({tag, "_araddr"}, 64'(bus.araddr), 64'(v.addr));
            bus.arready = 1'b1; @(negedge aclk); bus.arready = 1'b0;
            check({tag, "_arvalid_drop"}, 64'(bus.arvalid), 64'd0);
            wait_ch(4, ok); check({tag, "_r_seen"}, 64'(ok), 64'd1);
            if (v.stray) begin bus.bvalid = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1; bus.bresp = 2'b10; end
            repeat (v.r_d) begin
                check({tag, "_rready_hold"}, 64'(bus.rready), 64'd1);
                @(negedge aclk);
            end
            bus.rdata = v.rdata; bus.rvalid = 1'b1; bus.rlast = 1'($urandom);
            @(negedge aclk);
            bus.rvalid = 1'b0; bus.rdata = $urandom;
            bus.bvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
            check({tag, "_rready_drop"}, 64'(bus.rready), 64'd0);
        end
        wait_ch(5, ok); check({tag, "_rsp_seen"}, 64'(ok), 64'd1);
        check({tag, "_latency"}, 64'(cyc - t0), 64'(v.exp_lat));
        check({tag, "_rsp"}, 64'({rsp_timeout, rsp_err}), 64'({1'b0, v.exp_err}));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        @(negedge aclk);
        check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
        check({tag, "_hold"}, 64'({rsp_err, rsp_rdata}), 64'({v.exp_err, v.exp_rdata}));
        check({tag, "_hs_count"}, 64'({aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0, r_hs - r0}),
              v.write ? 64'({32'd1, 32'd1, 32'd1, 32'd0, 32'd0}) : 64'({32'd0, 32'd0, 32'd0, 32'd1, 32'd1}));
    endtask

    task automatic pulse_reset();
        @(negedge aclk); areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    vec_t          tbl[8];
    vec_t          rv;
    logic [DW-1:0] model_rdata;
    bit            ok;
    int            t0;

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;

        tbl[0] = mkw(32'h10, 32'h41,        0, 0, 0, 2'b00, 1'b0, 32'h0, 4);
        tbl[1] = mkr(32'h14, 0, 3, 32'h1,   1'b0, 32'h1, 6);
        tbl[2] = mkw(32'h20, 32'hDEADBEEF,  5, 7, 0, 2'b00, 1'b0, 32'h1, 16);
        tbl[3] = mkw(32'h24, 32'h55,        0, 0, 0, 2'b10, 1'b1, 32'h1, 4);
        tbl[4] = mkw(32'h28, 32'h66,        1, 0, 2, 2'b11, 1'b1, 32'h1, 7);
        tbl[5] = mkr(32'h2C, 2, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 5);
        tbl[6] = mkr(32'h30, 0, 1, 32'h12345678, 1'b1, 32'h12345678, 4);
        tbl[7] = mkw(32'h34, 32'h77,        0, 0, 0, 2'b01, 1'b1, 32'h12345678, 4);

        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_outputs", 64'({rsp_valid, rsp_err, rsp_timeout, bus.awvalid, bus.wvalid, bus.bready,
                                  bus.arvalid, bus.rready}), 64'd0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        #1 check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of a write data phase.
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hA5A5;
        @(negedge aclk); cmd_valid = 1'b0;
        wait_ch(0, ok); bus.awready = 1'b1; @(negedge aclk); bus.awready = 1'b0;
        wait_ch(1, ok); check("mid_in_wdata", 64'(ok), 64'd1);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1 check("mid_async_zero", 64'({cmd_ready, rsp_valid, rsp_err, bus.awvalid, bus.wvalid, bus.wlast,
                                         bus.bready, bus.arvalid, bus.rready}), 64'd0);
        check("mid_regs_zero", 64'({bus.wdata, rsp_rdata}), 64'd0);
        repeat (2) begin @(negedge aclk); check("mid_no_rsp", 64'(rsp_valid), 64'd0); end
        areset = 1'b0;
        #1 check("mid_rel_ready", 64'(cmd_ready), 64'd1);
        repeat (3) begin @(negedge aclk); check("mid_no_rsp_after", 64'(rsp_valid), 64'd0); end
        model_rdata = '0;
        run_txn(mkw(32'h44, 32'h99, 0, 0, 0, 2'b00, 1'b0, 32'h0, 4), "post_rst");

        // Read address channel never accepted.
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
        t0 = cyc;
        @(negedge aclk); cmd_valid = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        wait_ch(5, ok);
        check("tmo_seen", 64'(ok), 64'd1);
        check("tmo_latency", 64'(cyc - t0), 64'd17);
        check("tmo_arvalid", 64'(bus.arvalid), 64'd0);
        check("tmo_flags", 64'({rsp_err, rsp_timeout}), 64'b11);
        check("tmo_rdata", 64'(rsp_rdata), 64'(model_rdata));
        @(negedge aclk);
        check("tmo_pulse", 64'(rsp_valid), 64'd0);
        run_txn(mkr(32'h54, 0, 0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 3), "tmo_after");
        model_rdata = 32'h0BADF00D;
`else
        repeat (40) begin
            check("stall_state", 64'({bus.arvalid, rsp_valid, rsp_timeout}), 64'b100);
            @(negedge aclk);
        end
        pulse_reset();
        model_rdata = '0;
`endif

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                rv = mkw($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         2'($urandom), 1'b0, '0, 0);
                rv.exp_err   = (rv.bresp != 2'b00);
                rv.exp_rdata = model_rdata;
                rv.exp_lat   = 4 + rv.aw_d + rv.w_d + rv.b_d;
            end else begin
                rv = mkr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                         1'($urandom), '0, 0);
                rv.exp_rdata = rv.rdata;
                rv.exp_lat   = 3 + rv.ar_d + rv.r_d;
                model_rdata  = rv.rdata;
            end
            run_txn(rv, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
